// File: rtl/dmem_pkg.sv
// Shared definitions for the lane serialiser: FSM state encoding, transfer
// size codes and default geometry.
package dmem_pkg;

  localparam int unsigned DEF_WORD_W = 32;
  localparam int unsigned DEF_LANE_W = 8;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_XFER = 1'b1
  } dmem_state_e;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

endpackage

// File: rtl/dmem_lane_mux.sv
// Combinational lane selector: picks one LANE_W-wide slice of a word.
module dmem_lane_mux #(
  parameter int unsigned WORD_W = 32,
  parameter int unsigned LANE_W = 8
) (
  input  logic [WORD_W-1:0]                   word,
  input  logic [$clog2(WORD_W/LANE_W)-1:0]    lane,
  output logic [LANE_W-1:0]                   data_c
);

  localparam int unsigned NLANE = WORD_W / LANE_W;

  logic [NLANE-1:0][LANE_W-1:0] lanes;

  assign lanes  = word;
  assign data_c = lanes[lane];

endmodule

// File: rtl/dmem_lane_ser.sv
// Serialises a captured word into 2^size lanes starting at an aligned lane
// offset, in ascending or descending lane order, with valid/ready handshake.
module dmem_lane_ser
  import dmem_pkg::*;
#(
  parameter int unsigned WORD_W = DEF_WORD_W,
  parameter int unsigned LANE_W = DEF_LANE_W
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                start,
  input  logic [1:0]                          size,
  input  logic [$clog2(WORD_W/LANE_W)-1:0]    offset,
  input  logic                                big_end,
  input  logic [WORD_W-1:0]                   in_data,
  input  logic                                abort,
  input  logic                                out_ready,
  output logic                                out_valid,
  output logic [LANE_W-1:0]                   out_data,
  output logic [$clog2(WORD_W/LANE_W)-1:0]    out_lane,
  output logic                                out_last,
  output logic                                busy,
  output logic                                done,
  output logic                                err
);

  localparam int unsigned NLANE = WORD_W / LANE_W;
  localparam int unsigned LW    = $clog2(NLANE);

  localparam logic [0:0] IDLE = S_IDLE;
  localparam logic [0:0] XFER = S_XFER;

  // Number of lanes minus one for a size code (also the alignment mask).
  function automatic logic [LW-1:0] lanes_m1(input logic [1:0] sz);
    lanes_m1 = LW'((32'd1 << sz) - 32'd1);
  endfunction

  logic [0:0]        state_q, state_nxt;
  logic [WORD_W-1:0] word_q, word_nxt;
  logic [1:0]        size_q, size_nxt;
  logic [LW-1:0]     off_q, off_nxt;
  logic [LW-1:0]     k_q, k_nxt;
  logic              be_q, be_nxt;
  logic              done_nxt, err_nxt;
  logic              size_ok, aligned;
  logic              xfer_nxt, last_nxt;
  logic [LW-1:0]     lane_nxt;
  logic [LANE_W-1:0] lane_data;

  assign size_ok = 32'(size) <= LW;
  assign aligned = (offset & lanes_m1(size)) == '0;

  // Next-state, capture and beat-counter logic.
  always_comb begin
    state_nxt = state_q;
    word_nxt  = word_q;
    size_nxt  = size_q;
    off_nxt   = off_q;
    be_nxt    = be_q;
    k_nxt     = k_q;
    done_nxt  = 1'b0;
    err_nxt   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          if (size_ok && aligned) begin
            word_nxt  = in_data;
            size_nxt  = size;
            off_nxt   = offset;
            be_nxt    = big_end;
            k_nxt     = '0;
            state_nxt = XFER;
          end else begin
            err_nxt = 1'b1;
          end
        end
      end
      XFER: begin
        if (abort) begin
          state_nxt = IDLE;
        end else if (out_ready) begin
          if (k_q == lanes_m1(size_q)) begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
          end else begin
            k_nxt = k_q + LW'(1);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Beat presented next cycle; lane arithmetic wraps modulo NLANE.
  assign xfer_nxt = state_nxt == XFER;
  assign lane_nxt = be_nxt ? (off_nxt + lanes_m1(size_nxt) - k_nxt) : (off_nxt + k_nxt);
  assign last_nxt = k_nxt == lanes_m1(size_nxt);

  dmem_lane_mux #(
    .WORD_W (WORD_W),
    .LANE_W (LANE_W)
  ) u_mux (
    .word   (word_nxt),
    .lane   (lane_nxt),
    .data_c (lane_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      word_q    <= '0;
      size_q    <= '0;
      off_q     <= '0;
      be_q      <= 1'b0;
      k_q       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_lane  <= '0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state_q   <= state_nxt;
      word_q    <= word_nxt;
      size_q    <= size_nxt;
      off_q     <= off_nxt;
      be_q      <= be_nxt;
      k_q       <= k_nxt;
      out_valid <= xfer_nxt;
      out_data  <= xfer_nxt ? lane_data : '0;
      out_lane  <= xfer_nxt ? lane_nxt : '0;
      out_last  <= xfer_nxt & last_nxt;
      busy      <= xfer_nxt;
      done      <= done_nxt;
      err       <= err_nxt;
    end
  end

endmodule

// File: tb/tb_dmem_lane_ser.sv
// Self-checking bench for dmem_lane_ser: vector table plus hand-written
// stall/abort/reset/back-to-back sequences, and a 64/16 instance.
module tb_dmem_lane_ser;
  import dmem_pkg::*;

  logic        clk = 1'b0;
  logic        rst, start, big_end, abort, out_ready;
  logic [1:0]  size, offset;
  logic [31:0] in_data;
  logic        out_valid, out_last, busy, done, err;
  logic [7:0]  out_data;
  logic [1:0]  out_lane;

  logic        w_start, w_big_end, w_abort, w_out_ready;
  logic [1:0]  w_size, w_offset;
  logic [63:0] w_in_data;
  logic        w_out_valid, w_out_last, w_busy, w_done, w_err;
  logic [15:0] w_out_data;
  logic [1:0]  w_out_lane;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] word;
    logic [1:0]  sz;
    logic [1:0]  off;
    logic        be;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic [63:0] data;
    logic [1:0]  lane;
    logic        last;
  } beat_t;

  beat_t sb[$];
  vec_t  vecs[9];

  always #5 clk = ~clk;

  dmem_lane_ser dut (
    .clk(clk), .rst(rst), .start(start), .size(size), .offset(offset),
    .big_end(big_end), .in_data(in_data), .abort(abort), .out_ready(out_ready),
    .out_valid(out_valid), .out_data(out_data), .out_lane(out_lane),
    .out_last(out_last), .busy(busy), .done(done), .err(err)
  );

  dmem_lane_ser #(.WORD_W(64), .LANE_W(16)) dut_w (
    .clk(clk), .rst(rst), .start(w_start), .size(w_size), .offset(w_offset),
    .big_end(w_big_end), .in_data(w_in_data), .abort(w_abort), .out_ready(w_out_ready),
    .out_valid(w_out_valid), .out_data(w_out_data), .out_lane(w_out_lane),
    .out_last(w_out_last), .busy(w_busy), .done(w_done), .err(w_err)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference beat sequence for one transfer, four lanes per word.
  task automatic push_model(input logic [63:0] word, input int lw, input logic [1:0] sz,
                            input logic [1:0] off, input logic be);
    int n;
    int l;
    beat_t b;
    n = 1 << sz;
    for (int k = 0; k < n; k++) begin
      l = be ? ((int'(off) + n - 1 - k) % 4) : ((int'(off) + k) % 4);
      b.data = (word >> (l * lw)) & ((64'd1 << lw) - 64'd1);
      b.lane = 2'(l);
      b.last = (k == n - 1);
      sb.push_back(b);
    end
  endtask

  task automatic run_err(input logic [31:0] word, input logic [1:0] sz, input logic [1:0] off);
    in_data = word; size = sz; offset = off; big_end = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    chk("err_pulse", err, 1'b1);
    chk("err_busy", busy, 1'b0);
    chk("err_valid", out_valid, 1'b0);
    tick();
    chk("err_clear", err, 1'b0);
    chk("err_busy2", busy, 1'b0);
  endtask

  task automatic run_xfer(input logic [31:0] word, input logic [1:0] sz, input logic [1:0] off,
                          input logic be, input int stall_beat, input int stall_len,
                          input int abort_beat, input bit poke);
    int  n, beats, stall_cnt, cyc;
    bit  fin;
    beat_t e;
    n = 1 << sz;
    push_model({32'd0, word}, 8, sz, off, be);
    in_data = word; size = sz; offset = off; big_end = be; start = 1'b1; out_ready = 1'b1;
    tick();
    start = 1'b0;
    in_data = 32'h1234_5678;
    beats = 0; stall_cnt = 0; cyc = 1; fin = 1'b0;
    while (!fin && cyc <= 40) begin
      start = 1'b0;
      abort = 1'b0;
      if (beats < n) begin
        e = sb[0];
        chk("valid", out_valid, 1'b1);
        chk("busy", busy, 1'b1);
        chk("no_done", done, 1'b0);
        chk("no_err", err, 1'b0);
        chk("data", out_data, e.data);
        chk("lane", out_lane, e.lane);
        chk("last", out_last, e.last);
        if (beats == abort_beat) begin
          abort = 1'b1;
          tick();
          abort = 1'b0;
          chk("abort_valid", out_valid, 1'b0);
          chk("abort_busy", busy, 1'b0);
          chk("abort_done", done, 1'b0);
          tick();
          chk("abort_done2", done, 1'b0);
          sb.delete();
          fin = 1'b1;
        end else if (beats == stall_beat && stall_cnt < stall_len) begin
          out_ready = 1'b0;
          stall_cnt++;
          if (poke) begin
            start = 1'b1; in_data = 32'hFFFF_FFFF; size = SZ_HALF; offset = 2'd1;
          end
        end else begin
          out_ready = 1'b1;
          void'(sb.pop_front());
          beats++;
        end
      end else begin
        chk("done", done, 1'b1);
        chk("done_valid", out_valid, 1'b0);
        chk("done_busy", busy, 1'b0);
        chk("done_err", err, 1'b0);
        chk("done_cycle", 64'(cyc), 64'(n + 1 + stall_len));
        tick();
        chk("done_pulse", done, 1'b0);
        fin = 1'b1;
      end
      if (!fin) begin
        tick();
        cyc++;
      end
    end
    chk("xfer_end", fin, 1'b1);
    out_ready = 1'b1;
  endtask

  initial begin
    vecs[0] = '{32'hDDCC_BBAA, SZ_WORD, 2'd0, 1'b0, 1'b0};
    vecs[1] = '{32'hDDCC_BBAA, SZ_WORD, 2'd0, 1'b1, 1'b0};
    vecs[2] = '{32'hDDCC_BBAA, SZ_HALF, 2'd2, 1'b0, 1'b0};
    vecs[3] = '{32'hDDCC_BBAA, SZ_HALF, 2'd1, 1'b0, 1'b1};
    vecs[4] = '{32'hDDCC_BBAA, 2'd3,    2'd0, 1'b0, 1'b1};
    vecs[5] = '{32'hDDCC_BBAA, SZ_BYTE, 2'd3, 1'b1, 1'b0};
    vecs[6] = '{32'h4433_2211, SZ_HALF, 2'd0, 1'b1, 1'b0};
    vecs[7] = '{32'h4433_2211, SZ_WORD, 2'd1, 1'b0, 1'b1};
    vecs[8] = '{32'hDDCC_BBAA, SZ_HALF, 2'd2, 1'b1, 1'b0};

    rst = 1'b1; start = 1'b0; size = '0; offset = '0; big_end = 1'b0;
    in_data = '0; abort = 1'b0; out_ready = 1'b1;
    w_start = 1'b0; w_size = '0; w_offset = '0; w_big_end = 1'b0;
    w_in_data = '0; w_abort = 1'b0; w_out_ready = 1'b1;
    tick();
    tick();
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_data", out_data, 8'h00);
    chk("rst_lane", out_lane, 2'd0);
    chk("rst_last", out_last, 1'b0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 9; i++) begin
      if (vecs[i].exp_err) run_err(vecs[i].word, vecs[i].sz, vecs[i].off);
      else run_xfer(vecs[i].word, vecs[i].sz, vecs[i].off, vecs[i].be, -1, 0, -1, 1'b0);
    end

    // Stall on beat 1 for three cycles, with a start poked while busy.
    run_xfer(32'hDDCC_BBAA, SZ_WORD, 2'd0, 1'b0, 1, 3, -1, 1'b1);
    chk("poke_no_err", err, 1'b0);

    // Abort on beat 2.
    run_xfer(32'hDDCC_BBAA, SZ_WORD, 2'd0, 1'b0, -1, 0, 2, 1'b0);

    // Abort together with start in IDLE: start is dropped.
    in_data = 32'hDDCC_BBAA; size = SZ_WORD; offset = 2'd0; start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    chk("abst_busy", busy, 1'b0);
    chk("abst_valid", out_valid, 1'b0);
    chk("abst_err", err, 1'b0);

    // Back-to-back: start accepted in the done cycle.
    in_data = 32'hDDCC_BBAA; size = SZ_BYTE; offset = 2'd1; big_end = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    chk("b2b_data0", out_data, 8'hBB);
    chk("b2b_lane0", out_lane, 2'd1);
    chk("b2b_last0", out_last, 1'b1);
    tick();
    chk("b2b_done0", done, 1'b1);
    offset = 2'd3; start = 1'b1;
    tick();
    start = 1'b0;
    chk("b2b_valid1", out_valid, 1'b1);
    chk("b2b_data1", out_data, 8'hDD);
    chk("b2b_lane1", out_lane, 2'd3);
    chk("b2b_ndone", done, 1'b0);
    tick();
    chk("b2b_done1", done, 1'b1);
    tick();

    // Reset in the middle of a word transfer.
    in_data = 32'hDDCC_BBAA; size = SZ_WORD; offset = 2'd0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("pre_rst_data", out_data, 8'hBB);
    rst = 1'b1;
    tick();
    chk("mrst_valid", out_valid, 1'b0);
    chk("mrst_busy", busy, 1'b0);
    chk("mrst_data", out_data, 8'h00);
    chk("mrst_lane", out_lane, 2'd0);
    chk("mrst_last", out_last, 1'b0);
    chk("mrst_done", done, 1'b0);
    chk("mrst_err", err, 1'b0);
    rst = 1'b0;
    tick();
    chk("post_rst_busy", busy, 1'b0);

    // 64-bit word, 16-bit lanes.
    push_model(64'h4444_3333_2222_1111, 16, SZ_WORD, 2'd0, 1'b0);
    w_in_data = 64'h4444_3333_2222_1111; w_size = SZ_WORD; w_offset = 2'd0; w_start = 1'b1;
    tick();
    w_start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      beat_t e;
      e = sb.pop_front();
      chk("w_valid", w_out_valid, 1'b1);
      chk("w_data", w_out_data, e.data);
      chk("w_lane", w_out_lane, e.lane);
      chk("w_last", w_out_last, e.last);
      tick();
    end
    chk("w_done", w_done, 1'b1);
    chk("w_valid_end", w_out_valid, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmem_lane_ser.md
DMEM_LANE_SER -- requirements
Module: dmem_lane_ser

Interface
REQ-001 Parameter WORD_W, default 32, captured word width; SHALL be an integer multiple of LANE_W.
REQ-002 Parameter LANE_W, default 8, width of one output lane.
REQ-003 Derived constant NLANE = WORD_W/LANE_W, a power of two ≥2; LW = log2(NLANE).
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 start  in  1  request a transfer; sampled only when busy=0.
REQ-007 size  in  2  transfer length code: 2^size lanes; legal 0..LW.
REQ-008 offset  in  LW  starting lane index within the word.
REQ-009 big_end  in  1  lane order: 0 ascending, 1 descending.
REQ-010 in_data  in  WORD_W  word to serialise, captured on accepted start.
REQ-011 abort  in  1  cancel the current transfer.
REQ-012 out_ready  in  1  downstream accepts the current lane.
REQ-013 out_valid  out  1  out_data/out_lane/out_last valid.
REQ-014 out_data  out  LANE_W  current lane data.
REQ-015 out_lane  out  LW  lane index of current beat.
REQ-016 out_last  out  1  current beat is final beat.
REQ-017 busy  out  1  transfer in progress.
REQ-018 done  out  1  one-cycle pulse after final handshake.
REQ-019 err  out  1  one-cycle pulse on rejected request.

Function
REQ-020 States: IDLE, XFER; busy SHALL equal (state==XFER).
REQ-021 In IDLE, start=1 with legal size and offset mod 2^size == 0 SHALL capture in_data, size, offset, big_end, clear beat counter k, enter XFER.
REQ-022 In IDLE, start=1 with size>LW or misaligned offset SHALL assert err next cycle for one cycle, stay IDLE, capture nothing.
REQ-023 start while busy=1 SHALL be ignored (no capture, no err).
REQ-024 out_valid SHALL be 1 exactly while in XFER; first beat the cycle after start.
REQ-025 Beat k lane index L = offset+k (big_end=0) or offset+N-1-k (big_end=1), N=2^size; arithmetic modulo NLANE.
REQ-026 out_data SHALL equal captured word bits [L*LANE_W +: LANE_W]; out_lane = L; out_last = (k==N-1).
REQ-027 k SHALL advance only on out_valid & out_ready; outputs SHALL hold stable while out_valid & !out_ready.
REQ-028 Handshake on out_last SHALL return to IDLE next cycle with done=1 for exactly one cycle.
REQ-029 With out_ready held 1, an N-lane transfer SHALL occupy N cycles of out_valid; done at cycle N+1 after the start cycle.
REQ-030 start in the cycle done=1 SHALL be accepted (back-to-back, no bubble beyond the IDLE cycle).
REQ-031 abort=1 SHALL force IDLE next cycle, drop out_valid, suppress done; abort in IDLE has no effect; abort with start in IDLE SHALL let abort win (start ignored).
REQ-032 err and done SHALL never be asserted together.

Reset
REQ-033 rst=1 at a clock edge SHALL force IDLE and clear busy, out_valid, out_last, done, err, out_data, out_lane, k and captured registers to 0, including mid-transfer.
REQ-034 rst SHALL take priority over start and abort.

Structure
REQ-035 Package dmem_pkg SHALL hold the state enum, size codes (SZ_BYTE=0, SZ_HALF=1, SZ_WORD=2) and default WORD_W/LANE_W.
REQ-036 Lane extraction SHALL be a combinational sub-module dmem_lane_mux (word, lane index -> lane data), parametrised on WORD_W/LANE_W.

Verification
REQ-037 Defaults, in_data=0xDDCCBBAA, size=2, offset=0, big_end=0, ready=1 -> beats AA,BB,CC,DD lanes 0..3, last on DD, done 5 cycles after start.
REQ-038 Same word, big_end=1 -> DD,CC,BB,AA lanes 3..0; size=1 offset=2 big_end=0 -> CC,DD then done.
REQ-039 size=1 offset=1 -> err one cycle, busy stays 0; size=3 (defaults) -> err.
REQ-040 Word transfer, out_ready low 3 cycles on beat 1 -> BB held stable 3 cycles, completes with done; start mid-transfer ignored.
REQ-041 abort on beat 2 -> out_valid 0 next cycle, no done; rst mid-transfer -> all outputs 0 next cycle.
REQ-042 WORD_W=64, LANE_W=16, size=2 offset=0 -> four 16-bit beats in lane order 0..3.
